// File: rtl/var_delay_line_pkg.sv
// Shared definitions for the delay line: FSM state encoding, delay clamp helper
// and the NTT utility constants used alongside it.
package var_delay_line_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } vdl_state_e;

    localparam int unsigned NTT_Q     = 3329;
    localparam int unsigned NTT_N     = 256;
    localparam int unsigned NTT_LOG_N = 8;

    // Maps a requested delay onto the usable range 1..max_delay.
    function automatic int unsigned clamp_delay(input int unsigned req,
                                                input int unsigned max_delay);
        if (req == 0)
            return 1;
        if (req > max_delay)
            return max_delay;
        return req;
    endfunction

endpackage

// File: rtl/var_delay_line_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// On an address collision the read returns the contents from before the write.
module dp_ram_1r1w #(
    parameter int WIDTH  = 33,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        if (we)
            mem[waddr] <= wdata;
    end

endmodule

// File: rtl/var_delay_line.sv
// Programmable delay line: in_valid/data_in reappear exactly D cycles later,
// using a circular buffer whose output is gated until the line has refilled.
module var_delay_line
    import var_delay_line_pkg::*;
#(
    parameter int DATA      = 32,
    parameter int DEPTH_LOG = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DEPTH_LOG:0]   cfg_delay,
    input  logic                 cfg_load,
    output logic                 cfg_busy,
    input  logic                 in_valid,
    input  logic [DATA-1:0]      data_in,
    output logic                 out_valid,
    output logic [DATA-1:0]      data_out
);

    localparam int unsigned MAX_DELAY = 1 << DEPTH_LOG;

    typedef logic [DEPTH_LOG:0]   dly_t;
    typedef logic [DEPTH_LOG-1:0] addr_t;

    vdl_state_e      state, state_next;
    dly_t            delay_q, delay_req;
    dly_t            fill_cnt, fill_next;
    addr_t           wptr, raddr;
    logic            we;
    logic [DATA:0]   ram_q, byp_q, src;

    assign delay_req = dly_t'(clamp_delay(32'(cfg_delay), MAX_DELAY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fill_cnt <= '0;
            delay_q  <= dly_t'(1);
            wptr     <= '0;
        end else begin
            state    <= state_next;
            fill_cnt <= fill_next;
            wptr     <= wptr + addr_t'(1);
            if (cfg_load)
                delay_q <= delay_req;
        end
    end

    always_comb begin
        state_next = state;
        fill_next  = fill_cnt;
        if (cfg_load) begin
            state_next = FILL;
            fill_next  = '0;
        end else begin
            case (state)
                FILL: begin
                    if (fill_cnt == delay_q - dly_t'(1)) begin
                        state_next = RUN;
                        fill_next  = '0;
                    end else begin
                        fill_next = fill_cnt + dly_t'(1);
                    end
                end
                default: ;
            endcase
        end
        cfg_busy = (state == FILL);
        we       = (state != IDLE);
    end

    // The RAM is read one cycle ahead (offset D-1) so the output register can
    // still hold data_out across invalid slots; D=1 collides with the write
    // address, so that case is served from a one-entry bypass register.
    assign raddr = wptr - addr_t'(delay_q - dly_t'(1));

    dp_ram_1r1w #(
        .WIDTH  (DATA + 1),
        .ADDR_W (DEPTH_LOG)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata ({in_valid, data_in}),
        .raddr (raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        byp_q <= {in_valid, data_in};
    end

    assign src = (delay_q == dly_t'(1)) ? byp_q : ram_q;

    // A load suppresses the output at once so no pre-load word escapes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (state == RUN && !cfg_load) begin
            out_valid <= src[DATA];
            if (src[DATA])
                data_out <= src[DATA-1:0];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_var_delay_line.sv
// Scoreboard bench for var_delay_line: expected words are queued with their due
// cycle when driven and matched against the output on the falling edge.
module tb_var_delay_line;

    localparam int DATA = 32;
    localparam int DL   = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic [DL:0]     cfg_delay;
    logic            cfg_load;
    logic            cfg_busy;
    logic            in_valid;
    logic [DATA-1:0] data_in;
    logic            out_valid;
    logic [DATA-1:0] data_out;

    typedef struct {
        logic [DATA-1:0] data;
        int              due;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              cur_d = 1;
    int              n_out = 0;
    bit              armed = 1'b0;
    logic [DATA-1:0] last_data = '0;

    always #5 clk = ~clk;

    var_delay_line #(.DATA(DATA), .DEPTH_LOG(DL)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_delay (cfg_delay),
        .cfg_load  (cfg_load),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            last_data = '0;
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_output: cycle %0d, word %h due at cycle %0d never appeared",
                         cyc, sb[0].data, sb[0].due);
                void'(sb.pop_front());
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    errors++;
                    $display("FAIL unexpected_output: cycle %0d out_valid=1 data_out=%h, required out_valid=0",
                             cyc, data_out);
                end else begin
                    if (data_out !== sb[0].data) begin
                        errors++;
                        $display("FAIL output_data: cycle %0d data_out=%h, required %h",
                                 cyc, data_out, sb[0].data);
                    end
                    void'(sb.pop_front());
                    n_out++;
                end
                last_data = data_out;
            end else begin
                checks++;
                if (out_valid !== 1'b0 || data_out !== last_data) begin
                    errors++;
                    $display("FAIL idle_hold: cycle %0d out_valid=%b data_out=%h, required 0 / %h",
                             cyc, out_valid, data_out, last_data);
                end
            end
        end
    end

    task automatic send(input logic v, input logic [DATA-1:0] d);
        exp_t e;
        in_valid = v;
        data_in  = d;
        if (v && armed) begin
            e.data = d;
            e.due  = cyc + 1 + cur_d;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DL:0] d, input int eff);
        cfg_delay = d;
        cfg_load  = 1'b1;
        in_valid  = 1'b0;
        while (sb.size() > 0 && sb[$].due > cyc)
            void'(sb.pop_back());
        cur_d = eff;
        armed = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++)
            send(1'b0, '0);
        send(1'b0, '0);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cfg_load  = 1'b0;
        cfg_delay = '0;
        in_valid  = 1'b0;
        data_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy: got %b, required 0", cfg_busy); end
        if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h, required 0", data_out); end
        reset = 1'b0;
        armed = 1'b0;
        for (int i = 0; i < 12; i++)
            send(1'b1, 32'hDEAD_0000 + i);
        checks++;
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", cfg_busy); end
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        int n0;
        load(7'd5, 5);
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            if (cfg_busy === 1'b1) busy_cnt++;
            send(1'b1, i);
        end
        drain();
        checks += 3;
        if (busy_cnt != 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d, required 5", busy_cnt); end
        if (sb.size() != 0) begin errors++; $display("FAIL basic_drain: %0d words left, required 0", sb.size()); end
        if (n_out - n0 != 100) begin errors++; $display("FAIL basic_count: got %0d words, required 100", n_out - n0); end
    endtask

    task automatic test_full_depth();
        int n0;
        load(7'd64, 64);
        n0 = n_out;
        for (int i = 0; i < 200; i++)
            send(1'b1, 1000 + i);
        drain();
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL full_drain: %0d words left, required 0", sb.size()); end
        if (n_out - n0 != 200) begin errors++; $display("FAIL full_count: got %0d words, required 200", n_out - n0); end
    endtask

    task automatic test_clamp();
        int n0;
        load(7'd0, 1);
        n0 = n_out;
        for (int i = 0; i < 10; i++)
            send(1'b1, 32'h0C00_0000 + i);
        drain();
        checks++;
        if (n_out - n0 != 10) begin errors++; $display("FAIL clamp_low_count: got %0d words, required 10", n_out - n0); end
        load(7'd100, 64);
        n0 = n_out;
        for (int i = 0; i < 70; i++)
            send(1'b1, 32'h0C10_0000 + i);
        drain();
        checks++;
        if (n_out - n0 != 70) begin errors++; $display("FAIL clamp_high_count: got %0d words, required 70", n_out - n0); end
    endtask

    task automatic test_reload();
        int n0;
        load(7'd8, 8);
        for (int i = 0; i < 20; i++)
            send(1'b1, 2000 + i);
        load(7'd3, 3);
        n0 = n_out;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reload_gap: step %0d out_valid=%b, required 0", i, out_valid);
            end
            send(1'b1, 3000 + i);
        end
        for (int i = 3; i < 20; i++)
            send(1'b1, 3000 + i);
        drain();
        checks++;
        if (n_out - n0 != 20) begin errors++; $display("FAIL reload_count: got %0d words, required 20", n_out - n0); end
    endtask

    task automatic test_valid_pattern();
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int n0;
        load(7'd4, 4);
        n0 = n_out;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 5; i++)
                send(pat[i], 4000 + r * 5 + i);
        drain();
        checks++;
        if (n_out - n0 != 9) begin errors++; $display("FAIL pattern_count: got %0d words, required 9", n_out - n0); end
    endtask

    task automatic test_reset_mid_run();
        int n0;
        load(7'd6, 6);
        for (int i = 0; i < 20; i++)
            send(1'b1, 5000 + i);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrun_active: out_valid=%b, required 1", out_valid); end
        reset = 1'b1;
        sb.delete();
        armed = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_reset_valid: got %b, required 0", out_valid); end
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %b, required 0", cfg_busy); end
        if (data_out !== '0) begin errors++; $display("FAIL midrun_reset_data: got %h, required 0", data_out); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++)
            send(1'b1, 6000 + i);
        load(7'd2, 2);
        n0 = n_out;
        for (int i = 0; i < 10; i++)
            send(1'b1, 7000 + i);
        drain();
        checks++;
        if (n_out - n0 != 10) begin errors++; $display("FAIL after_reset_count: got %0d words, required 10", n_out - n0); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_full_depth();
        test_clamp();
        test_reload();
        test_valid_pattern();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
